fsk_rx_controller: RTL

FSK_RX_CONTROLLER -- requirements
Module: fsk_rx_controller

---
 rtl/fsk_rx_controller.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fsk_rx_controller.sv
// fsk_rx_controller
// Frame receiver that sits behind an FSK demodulator. It hunts for a sync
// word in the decided bit stream, reads a length byte, then assembles the
// payload bytes MSB-first and hands them downstream with a valid/ready
// handshake. An optional trailing CRC-8 byte is checked before the frame is
// reported complete.
//
// Optional feature macro: FSK_RX_CRC_EN
//   defined   : CHECK state collects a CRC-8 byte (poly 0x07, init 0x00,
//               computed over the length byte and all payload bytes).
//   undefined : no CHECK state; frame_done pulses with the last payload byte.
//
// Parameters
//   SYNC_WORD   : sync pattern, matched MSB-first
//   MAX_LEN     : largest legal payload length in bytes (1..127)
//   TIMEOUT_CYC : clk cycles allowed between bit strobes inside a frame
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   receiver enable; low forces IDLE
//   bit_valid    in   one-cycle strobe marking a decided bit
//   bit_in       in   demodulated bit, qualified by bit_valid
//   demod_clear  out  one-cycle pulse resetting the demodulator accumulators
//   byte_data    out  received payload byte
//   byte_valid   out  byte_data valid, held until accepted
//   byte_ready   in   downstream accept
//   frame_start  out  one-cycle pulse on sync match
//   frame_done   out  one-cycle pulse when a frame completes cleanly
//   frame_err    out  one-cycle pulse on any frame abort
//   busy         out  high while inside a frame (LEN, PAYLOAD, CHECK)
module fsk_rx_controller #(
    parameter logic [7:0] SYNC_WORD   = 8'hD3,
    parameter int         MAX_LEN     = 64,
    parameter int         TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       demod_clear,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HUNT    = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
`ifdef FSK_RX_CRC_EN
    localparam logic [2:0] ST_CHECK   = 3'd4;
`endif

    localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);
    // Timeout fires on the edge where the idle count would reach TIMEOUT_CYC.
    localparam logic [13:0] TIMEOUT_LIM = 14'(TIMEOUT_CYC - 1);
    localparam logic [13:0] IDLE_SAT    = 14'h3FFF;

`ifdef FSK_RX_CRC_EN
    // CRC-8, polynomial x^8+x^2+x+1, MSB-first, one byte per call.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                               input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    logic [2:0]  state_r,     state_n;
    logic [7:0]  shift_r,     shift_n;
    logic [2:0]  bit_cnt_r,   bit_cnt_n;
    logic [6:0]  byte_cnt_r,  byte_cnt_n;
    logic [6:0]  len_r,       len_n;
    logic [13:0] idle_cnt_r,  idle_cnt_n;
`ifdef FSK_RX_CRC_EN
    logic [7:0]  crc_r,       crc_n;
`endif
    logic [7:0]  byte_data_r, byte_data_n;
    logic        byte_valid_r, byte_valid_n;
    logic        demod_clear_r, demod_clear_n;
    logic        frame_start_r, frame_start_n;
    logic        frame_done_r,  frame_done_n;
    logic        frame_err_r,   frame_err_n;
    logic        busy_r,        busy_n;

    logic [7:0]  shift_in_s;
    logic        byte_done_s;
    logic        timeout_s;
    logic        hold_s;

    assign shift_in_s  = {shift_r[6:0], bit_in};
    assign byte_done_s = bit_valid && (bit_cnt_r == 3'd7);
    // A bit strobe in the same cycle always beats the timeout.
    assign timeout_s   = !bit_valid && (idle_cnt_r >= TIMEOUT_LIM);
    // Byte still pending after this cycle's handshake.
    assign hold_s      = byte_valid_r && !byte_ready;

    // Saturating count of cycles since the last bit strobe.
    always_comb begin
        idle_cnt_n = idle_cnt_r;
        if (bit_valid) begin
            idle_cnt_n = 14'd0;
        end else if (idle_cnt_r != IDLE_SAT) begin
            idle_cnt_n = idle_cnt_r + 14'd1;
        end else begin
            idle_cnt_n = idle_cnt_r;
        end
    end

    // Next-state, datapath and output-pulse decode.
    always_comb begin
        state_n       = state_r;
        shift_n       = shift_r;
        bit_cnt_n     = bit_cnt_r;
        byte_cnt_n    = byte_cnt_r;
        len_n         = len_r;
`ifdef FSK_RX_CRC_EN
        crc_n         = crc_r;
`endif
        byte_data_n   = byte_data_r;
        byte_valid_n  = hold_s;
        demod_clear_n = 1'b0;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        frame_err_n   = 1'b0;

        if (!enable) begin
            state_n      = ST_IDLE;
            byte_valid_n = 1'b0;
            shift_n      = 8'h00;
            bit_cnt_n    = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n       = ST_HUNT;
                    demod_clear_n = 1'b1;
                    shift_n       = 8'h00;
                    bit_cnt_n     = 3'd0;
                end
                ST_HUNT: begin
                    if (bit_valid && (shift_in_s == SYNC_WORD)) begin
                        state_n       = ST_LEN;
                        frame_start_n = 1'b1;
                        shift_n       = 8'h00;
                        bit_cnt_n     = 3'd0;
                        byte_cnt_n    = 7'd0;
`ifdef FSK_RX_CRC_EN
                        crc_n         = 8'h00;
`endif
                    end else if (bit_valid) begin
                        shift_n = shift_in_s;
                    end else begin
                        shift_n = shift_r;
                    end
                end
                ST_LEN: begin
                    if (bit_valid) begin
                        shift_n   = byte_done_s ? 8'h00 : shift_in_s;
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (byte_done_s && ((shift_in_s == 8'h00) || (shift_in_s > MAX_LEN_B))) begin
                            state_n     = ST_HUNT;
                            frame_err_n = 1'b1;
                        end else if (byte_done_s) begin
                            state_n = ST_PAYLOAD;
                            len_n   = shift_in_s[6:0];
`ifdef FSK_RX_CRC_EN
                            crc_n   = crc8_update(crc_r, shift_in_s);
`endif
                        end else begin
                            state_n = ST_LEN;
                        end
                    end else if (timeout_s) begin
                        state_n       = ST_HUNT;
                        frame_err_n   = 1'b1;
                        demod_clear_n = 1'b1;
                        shift_n       = 8'h00;
                        bit_cnt_n     = 3'd0;
                    end else begin
                        state_n = ST_LEN;
                    end
                end
                ST_PAYLOAD: begin
                    if (bit_valid) begin
                        shift_n   = byte_done_s ? 8'h00 : shift_in_s;
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (byte_done_s && hold_s) begin
                            // Overrun: previous byte never taken.
                            state_n      = ST_HUNT;
                            frame_err_n  = 1'b1;
                            byte_valid_n = 1'b0;
                        end else if (byte_done_s) begin
                            byte_data_n  = shift_in_s;
                            byte_valid_n = 1'b1;
                            byte_cnt_n   = byte_cnt_r + 7'd1;
`ifdef FSK_RX_CRC_EN
                            crc_n        = crc8_update(crc_r, shift_in_s);
                            if ((byte_cnt_r + 7'd1) == len_r) begin
                                state_n = ST_CHECK;
                            end else begin
                                state_n = ST_PAYLOAD;
                            end
`else
                            if ((byte_cnt_r + 7'd1) == len_r) begin
                                state_n      = ST_HUNT;
                                frame_done_n = 1'b1;
                            end else begin
                                state_n = ST_PAYLOAD;
                            end
`endif
                        end else begin
                            state_n = ST_PAYLOAD;
                        end
                    end else if (timeout_s) begin
                        state_n       = ST_HUNT;
                        frame_err_n   = 1'b1;
                        demod_clear_n = 1'b1;
                        shift_n       = 8'h00;
                        bit_cnt_n     = 3'd0;
                    end else begin
                        state_n = ST_PAYLOAD;
                    end
                end
`ifdef FSK_RX_CRC_EN
                ST_CHECK: begin
                    if (bit_valid) begin
                        shift_n   = byte_done_s ? 8'h00 : shift_in_s;
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (byte_done_s && (shift_in_s == crc_r)) begin
                            state_n      = ST_HUNT;
                            frame_done_n = 1'b1;
                        end else if (byte_done_s) begin
                            state_n     = ST_HUNT;
                            frame_err_n = 1'b1;
                        end else begin
                            state_n = ST_CHECK;
                        end
                    end else if (timeout_s) begin
                        state_n       = ST_HUNT;
                        frame_err_n   = 1'b1;
                        demod_clear_n = 1'b1;
                        shift_n       = 8'h00;
                        bit_cnt_n     = 3'd0;
                    end else begin
                        state_n = ST_CHECK;
                    end
                end
`endif
                default: begin
                    state_n   = ST_IDLE;
                    shift_n   = 8'h00;
                    bit_cnt_n = 3'd0;
                end
            endcase
        end

`ifdef FSK_RX_CRC_EN
        busy_n = (state_n == ST_LEN) || (state_n == ST_PAYLOAD) || (state_n == ST_CHECK);
`else
        busy_n = (state_n == ST_LEN) || (state_n == ST_PAYLOAD);
`endif
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            shift_r       <= 8'h00;
            bit_cnt_r     <= 3'd0;
            byte_cnt_r    <= 7'd0;
            len_r         <= 7'd0;
            idle_cnt_r    <= 14'd0;
`ifdef FSK_RX_CRC_EN
            crc_r         <= 8'h00;
`endif
            byte_data_r   <= 8'h00;
            byte_valid_r  <= 1'b0;
            demod_clear_r <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            shift_r       <= shift_n;
            bit_cnt_r     <= bit_cnt_n;
            byte_cnt_r    <= byte_cnt_n;
            len_r         <= len_n;
            idle_cnt_r    <= idle_cnt_n;
`ifdef FSK_RX_CRC_EN
            crc_r         <= crc_n;
`endif
            byte_data_r   <= byte_data_n;
            byte_valid_r  <= byte_valid_n;
            demod_clear_r <= demod_clear_n;
            frame_start_r <= frame_start_n;
            frame_done_r  <= frame_done_n;
            frame_err_r   <= frame_err_n;
            busy_r        <= busy_n;
        end
    end

    assign demod_clear = demod_clear_r;
    assign byte_data   = byte_data_r;
    assign byte_valid  = byte_valid_r;
    assign frame_start = frame_start_r;
    assign frame_done  = frame_done_r;
    assign frame_err   = frame_err_r;
    assign busy        = busy_r;

endmodule
